// File: rtl/store_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : store_cache_controller
// Description : Store/invalidate sequencer between a core store port, a
//               cache array and a write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module store_cache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 8
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              inv_req_i,
    input  logic [ADDR_WIDTH-1:0]                             inv_addr_i,
    output logic                                              inv_ack_o,
    input  logic                                              st_req_i,
    input  logic [ADDR_WIDTH-1:0]                             st_addr_i,
    input  logic [DATA_WIDTH-1:0]                             st_data_i,
    input  logic [1:0]                                        st_width_i,
    output logic                                              st_ack_o,
    output logic                                              st_err_o,
    input  logic                                              cache_hit_i,
    output logic                                              cache_read_o,
    output logic                                              cache_write_o,
    output logic [INDEX_BITS-1:0]                             cache_index_o,
    output logic [ADDR_WIDTH-INDEX_BITS-$clog2(DATA_WIDTH/8)-1:0] cache_tag_o,
    output logic [DATA_WIDTH/8-1:0]                           cache_byte_en_o,
    output logic [DATA_WIDTH-1:0]                             cache_data_o,
    output logic                                              cache_dirty_o,
    output logic                                              cache_valid_o,
    output logic [3:0]                                        cache_en_o,
    output logic                                              wb_valid_o,
    input  logic                                              wb_ready_i,
    output logic [ADDR_WIDTH-1:0]                             wb_addr_o,
    output logic [DATA_WIDTH-1:0]                             wb_data_o,
    output logic [DATA_WIDTH/8-1:0]                           wb_byte_en_o,
    output logic                                              idle_o
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFS      = $clog2(BYTES);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFS;
    localparam int IDX_LO   = OFS;
    localparam int IDX_HI   = INDEX_BITS + OFS - 1;
    localparam logic [3:0] BYTES_C = 4'(BYTES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        WRITE      = 3'd2,
        BUFFER     = 3'd3,
        INVALIDATE = 3'd4
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [1:0]              lat_width;
    logic                    lat_inv;

    logic [OFS-1:0]          req_sel;
    logic [3:0]              req_size;
    logic                    store_bad;
    logic [INDEX_BITS-1:0]   req_index;

    logic [OFS-1:0]          lat_sel;
    logic [3:0]              lat_size;
    logic [DATA_WIDTH-1:0]   shifted_data;
    logic [BYTES-1:0]        lane_en;
    logic [DATA_WIDTH-1:0]   lane_data;
    logic [ADDR_WIDTH-1:0]   line_addr;

    // Alignment check: a store must fit the port and be naturally aligned.
    always_comb begin
        req_sel   = st_addr_i[OFS-1:0];
        req_size  = 4'd1 << st_width_i;
        store_bad = (req_size > BYTES_C) ||
                    ((4'(req_sel) & (req_size - 4'd1)) != 4'd0);
        req_index = inv_req_i ? inv_addr_i[IDX_HI:IDX_LO] : st_addr_i[IDX_HI:IDX_LO];
    end

    always_comb begin
        lat_sel      = lat_addr[OFS-1:0];
        lat_size     = 4'd1 << lat_width;
        shifted_data = lat_data << {lat_sel, 3'b000};
        lane_en      = '0;
        lane_data    = '0;
        for (int b = 0; b < BYTES; b++) begin
            lane_en[b] = (b >= int'(lat_sel)) && (b < int'(lat_sel) + int'(lat_size));
            lane_data[8*b +: 8] = lane_en[b] ? shifted_data[8*b +: 8] : 8'h00;
        end
        line_addr = {lat_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    end

    always_comb begin
        next_state      = state;
        inv_ack_o       = 1'b0;
        st_ack_o        = 1'b0;
        st_err_o        = 1'b0;
        cache_read_o    = 1'b0;
        cache_write_o   = 1'b0;
        cache_index_o   = '0;
        cache_tag_o     = '0;
        cache_byte_en_o = '0;
        cache_data_o    = '0;
        cache_dirty_o   = 1'b0;
        cache_valid_o   = 1'b0;
        cache_en_o      = 4'b0000;
        wb_valid_o      = 1'b0;
        wb_addr_o       = '0;
        wb_data_o       = '0;
        wb_byte_en_o    = '0;

        if (rst_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_req_i || (st_req_i && !store_bad)) begin
                        cache_read_o  = 1'b1;
                        cache_index_o = req_index;
                        cache_en_o    = 4'b1111;
                        next_state    = COMPARE;
                    end else if (st_req_i) begin
                        st_ack_o = 1'b1;
                        st_err_o = 1'b1;
                    end
                end
                COMPARE: begin
                    cache_tag_o = lat_addr[ADDR_WIDTH-1:INDEX_BITS+OFS];
                    if (lat_inv) begin
                        if (cache_hit_i) begin
                            next_state = INVALIDATE;
                        end else begin
                            inv_ack_o  = 1'b1;
                            next_state = IDLE;
                        end
                    end else begin
                        next_state = cache_hit_i ? WRITE : BUFFER;
                    end
                end
                WRITE: begin
                    cache_write_o   = 1'b1;
                    cache_index_o   = lat_addr[IDX_HI:IDX_LO];
                    cache_en_o      = 4'b0101;
                    cache_dirty_o   = 1'b1;
                    cache_byte_en_o = lane_en;
                    cache_data_o    = lane_data;
                    st_ack_o        = 1'b1;
                    next_state      = IDLE;
                end
                BUFFER: begin
                    wb_valid_o   = 1'b1;
                    wb_addr_o    = line_addr;
                    wb_data_o    = lane_data;
                    wb_byte_en_o = lane_en;
                    if (wb_ready_i) begin
                        st_ack_o   = 1'b1;
                        next_state = IDLE;
                    end
                end
                INVALIDATE: begin
                    cache_write_o = 1'b1;
                    cache_index_o = lat_addr[IDX_HI:IDX_LO];
                    cache_en_o    = 4'b0010;
                    inv_ack_o     = 1'b1;
                    next_state    = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end

        idle_o = (next_state == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_width <= 2'd0;
            lat_inv   <= 1'b0;
        end else begin
            state <= next_state;
            // Requests are captured only on the acceptance edge out of IDLE.
            if (state == IDLE && next_state == COMPARE) begin
                lat_inv   <= inv_req_i;
                lat_addr  <= inv_req_i ? inv_addr_i : st_addr_i;
                lat_data  <= st_data_i;
                lat_width <= st_width_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_cache_controller
// Description : Directed self-checking bench for store_cache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_cache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hit = 1'b0;
    logic wb_ready = 1'b0;

    logic        inv_req = 1'b0;
    logic [31:0] inv_addr = '0;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_width = '0;
    logic        inv_ack, st_ack, st_err, c_read, c_write, c_dirty, c_valid;
    logic [7:0]  c_index;
    logic [21:0] c_tag;
    logic [3:0]  c_be, c_en, wb_be;
    logic [31:0] c_data, wb_addr, wb_data;
    logic        wb_valid, idle;

    logic        st_req64 = 1'b0;
    logic [31:0] st_addr64 = '0;
    logic [63:0] st_data64 = '0;
    logic [1:0]  st_width64 = '0;
    logic        inv_ack64, st_ack64, st_err64, c_read64, c_write64, c_dirty64, c_valid64;
    logic [7:0]  c_index64;
    logic [20:0] c_tag64;
    logic [7:0]  c_be64, wb_be64;
    logic [3:0]  c_en64;
    logic [63:0] c_data64, wb_data64;
    logic [31:0] wb_addr64;
    logic        wb_valid64, idle64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_cache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .inv_req_i(inv_req), .inv_addr_i(inv_addr), .inv_ack_o(inv_ack),
        .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_width_i(st_width),
        .st_ack_o(st_ack), .st_err_o(st_err),
        .cache_hit_i(hit), .cache_read_o(c_read), .cache_write_o(c_write),
        .cache_index_o(c_index), .cache_tag_o(c_tag), .cache_byte_en_o(c_be),
        .cache_data_o(c_data), .cache_dirty_o(c_dirty), .cache_valid_o(c_valid),
        .cache_en_o(c_en), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
        .wb_addr_o(wb_addr), .wb_data_o(wb_data), .wb_byte_en_o(wb_be), .idle_o(idle)
    );

    store_cache_controller #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .INDEX_BITS(8)) dut64 (
        .clk_i(clk), .rst_i(rst),
        .inv_req_i(1'b0), .inv_addr_i(32'h0), .inv_ack_o(inv_ack64),
        .st_req_i(st_req64), .st_addr_i(st_addr64), .st_data_i(st_data64), .st_width_i(st_width64),
        .st_ack_o(st_ack64), .st_err_o(st_err64),
        .cache_hit_i(hit), .cache_read_o(c_read64), .cache_write_o(c_write64),
        .cache_index_o(c_index64), .cache_tag_o(c_tag64), .cache_byte_en_o(c_be64),
        .cache_data_o(c_data64), .cache_dirty_o(c_dirty64), .cache_valid_o(c_valid64),
        .cache_en_o(c_en64), .wb_valid_o(wb_valid64), .wb_ready_i(wb_ready),
        .wb_addr_o(wb_addr64), .wb_data_o(wb_data64), .wb_byte_en_o(wb_be64), .idle_o(idle64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_idle", idle, 1);
        check("rst_read", c_read, 0);
        check("rst_ack", st_ack, 0);
        check("rst_wbv", wb_valid, 0);

        // Byte store hit; upper data bits must be masked off.
        st_req = 1; st_addr = 32'h0000_1236; st_data = 32'hFFFF_FFAB; st_width = 2'd0; hit = 1;
        settle();
        check("b_c0_read", c_read, 1);
        check("b_c0_index", c_index, 8'h8D);
        check("b_c0_en", c_en, 4'b1111);
        check("b_c0_idle", idle, 0);
        tick(); settle();
        check("b_c1_tag", c_tag, 22'h4);
        check("b_c1_ack", st_ack, 0);
        tick(); settle();
        check("b_c2_write", c_write, 1);
        check("b_c2_index", c_index, 8'h8D);
        check("b_c2_be", c_be, 4'b0100);
        check("b_c2_data", c_data, 32'h00AB_0000);
        check("b_c2_en", c_en, 4'b0101);
        check("b_c2_dirty", c_dirty, 1);
        check("b_c2_ack", st_ack, 1);
        check("b_c2_err", st_err, 0);
        tick(); st_req = 0; settle();
        check("b_c3_idle", idle, 1);

        // Word store miss with three cycles of backpressure.
        st_req = 1; st_addr = 32'h0000_2000; st_data = 32'hDEAD_BEEF; st_width = 2'd2; hit = 0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("w_wbv", wb_valid, 1);
            check("w_addr", wb_addr, 32'h0000_2000);
            check("w_data", wb_data, 32'hDEAD_BEEF);
            check("w_be", wb_be, 4'b1111);
            check("w_noack", st_ack, 0);
            tick();
        end
        wb_ready = 1; settle();
        check("w_wbv_last", wb_valid, 1);
        check("w_ack", st_ack, 1);
        tick(); st_req = 0; wb_ready = 0; settle();
        check("w_idle", idle, 1);
        check("w_wbv_off", wb_valid, 0);

        // Half store miss at byte 2: upper half lanes, address line-aligned.
        st_req = 1; st_addr = 32'h0000_4402; st_data = 32'h1234_CDEF; st_width = 2'd1; hit = 0;
        wb_ready = 1;
        tick(); tick(); settle();
        check("h_be", wb_be, 4'b1100);
        check("h_data", wb_data, 32'hCDEF_0000);
        check("h_addr", wb_addr, 32'h0000_4400);
        check("h_ack", st_ack, 1);
        tick(); st_req = 0; wb_ready = 0;

        // Misaligned half and oversized double are rejected in cycle 0.
        st_req = 1; st_addr = 32'h0000_1001; st_width = 2'd1; settle();
        check("e_half_ack", st_ack, 1);
        check("e_half_err", st_err, 1);
        check("e_half_read", c_read, 0);
        check("e_half_wbv", wb_valid, 0);
        tick(); st_addr = 32'h0000_1000; st_width = 2'd3; settle();
        check("e_dbl_ack", st_ack, 1);
        check("e_dbl_err", st_err, 1);
        check("e_dbl_read", c_read, 0);
        tick(); st_req = 0; settle();
        check("e_idle", idle, 1);

        // Invalidate miss acks from COMPARE.
        inv_req = 1; inv_addr = 32'h0000_3004; hit = 0; settle();
        check("im_c0_index", c_index, 8'h01);
        tick(); settle();
        check("im_c1_ack", inv_ack, 1);
        tick(); inv_req = 0;

        // Simultaneous invalidate hit and store hit: invalidate first.
        inv_req = 1; inv_addr = 32'h0000_3004;
        st_req = 1; st_addr = 32'h0000_1236; st_data = 32'h0000_00AB; st_width = 2'd0; hit = 1;
        settle();
        check("pri_c0_index", c_index, 8'h01);
        check("pri_c0_ack", st_ack, 0);
        tick(); tick(); settle();
        check("pri_c2_iack", inv_ack, 1);
        check("pri_c2_en", c_en, 4'b0010);
        check("pri_c2_write", c_write, 1);
        check("pri_c2_valid", c_valid, 0);
        check("pri_c2_sack", st_ack, 0);
        tick(); inv_req = 0; settle();
        check("pri_c3_read", c_read, 1);
        check("pri_c3_index", c_index, 8'h8D);
        tick(); tick(); settle();
        check("pri_c5_ack", st_ack, 1);
        check("pri_c5_data", c_data, 32'h00AB_0000);
        tick(); st_req = 0;

        // Reset while the write buffer is being offered.
        st_req = 1; st_addr = 32'h0000_2000; st_data = 32'h5555_AAAA; st_width = 2'd2; hit = 0;
        tick(); tick(); settle();
        check("r_wbv", wb_valid, 1);
        rst = 1; st_req = 0;
        tick(); rst = 0; settle();
        check("r_wbv_off", wb_valid, 0);
        check("r_idle", idle, 1);
        check("r_noack", st_ack, 0);
        st_req = 1; st_addr = 32'h0000_1236; st_data = 32'h0000_00AB; st_width = 2'd0; hit = 1;
        tick(); tick(); settle();
        check("r_fresh_ack", st_ack, 1);
        check("r_fresh_be", c_be, 4'b0100);
        tick(); st_req = 0;

        // 64-bit port: aligned double store fills every lane.
        st_req64 = 1; st_addr64 = 32'h0000_1008; st_data64 = 64'h0123_4567_89AB_CDEF;
        st_width64 = 2'd3; hit = 1; settle();
        check("d_c0_err", st_err64, 0);
        check("d_c0_read", c_read64, 1);
        check("d_c0_index", c_index64, 8'h01);
        tick(); tick(); settle();
        check("d_c2_be", c_be64, 8'hFF);
        check("d_c2_data", c_data64, 64'h0123_4567_89AB_CDEF);
        check("d_c2_ack", st_ack64, 1);
        tick(); st_req64 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_cache_controller.md
STORE_CACHE_CONTROLLER -- requirements
Module: store_cache_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, cache port width in bits; legal values 32 or 64; BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
REQ-002 Parameter ADDR_WIDTH, default 32, full store address width.
REQ-003 Parameter INDEX_BITS, default 8, cache index width; TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFS.
REQ-004 Address layout SHALL be tag = addr[ADDR_WIDTH-1 : INDEX_BITS+OFS], index = addr[INDEX_BITS+OFS-1 : OFS], byte_sel = addr[OFS-1:0].
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 inv_req_i in 1 invalidate request, held until inv_ack_o; inv_addr_i in ADDR_WIDTH; inv_ack_o out 1 one-cycle completion pulse.
REQ-008 st_req_i in 1 store request, held until st_ack_o; st_addr_i in ADDR_WIDTH; st_data_i in DATA_WIDTH, right-aligned; st_width_i in 2 (0 byte, 1 half, 2 word, 3 double).
REQ-009 st_ack_o out 1 one-cycle store completion pulse; st_err_o out 1 valid with st_ack_o, marks a rejected store.
REQ-010 cache_hit_i in 1 tag-compare result, valid in COMPARE; cache_read_o, cache_write_o out 1; cache_index_o out INDEX_BITS; cache_tag_o out TAG_BITS.
REQ-011 cache_byte_en_o out BYTES; cache_data_o out DATA_WIDTH; cache_dirty_o, cache_valid_o out 1; cache_en_o out 4, bit order {tag, dirty, valid, data}.
REQ-012 wb_valid_o out 1; wb_ready_i in 1; wb_addr_o out ADDR_WIDTH, byte_sel bits zero; wb_data_o out DATA_WIDTH; wb_byte_en_o out BYTES.
REQ-013 idle_o out 1, high when the next state is IDLE.

Function
REQ-014 States: IDLE, COMPARE, WRITE, BUFFER, INVALIDATE; every output not explicitly driven in a state SHALL be 0.
REQ-015 IDLE: inv_req_i has priority over st_req_i; the accepted request's address, data, width and type SHALL be latched into registers; later steps use only latched values.
REQ-016 Size bytes = 1<<st_width_i; a store SHALL be rejected if size > BYTES or byte_sel mod size != 0.
REQ-017 Rejected store in IDLE: st_ack_o=1 and st_err_o=1 in the same cycle, no cache or write-buffer activity, state stays IDLE.
REQ-018 Accepted request in IDLE: cache_read_o=1, cache_index_o=request index, cache_en_o=4'b1111, next state COMPARE.
REQ-019 COMPARE: cache_tag_o=latched tag; invalidate hit -> INVALIDATE; invalidate miss -> inv_ack_o=1, IDLE; store hit -> WRITE; store miss -> BUFFER.
REQ-020 Byte enable = ((1<<size)-1) << byte_sel; lane data = st_data_i low size bytes shifted left by 8*byte_sel, other lanes 0.
REQ-021 WRITE: cache_write_o=1, latched index, cache_en_o=4'b0101 (dirty, data), cache_dirty_o=1, byte_en/data per REQ-020, st_ack_o=1, next IDLE; store hit latency 3 cycles from acceptance.
REQ-022 BUFFER: wb_valid_o=1 with wb_addr_o/wb_data_o/wb_byte_en_o per REQ-012/020, stable while wb_ready_i=0; on the cycle wb_ready_i=1: st_ack_o=1, next IDLE.
REQ-023 INVALIDATE: cache_write_o=1, latched index, cache_en_o=4'b0010, cache_valid_o=0, inv_ack_o=1, next IDLE.
REQ-024 A request arriving while not in IDLE SHALL wait; an invalidate pending during a store is served in the first IDLE cycle, before any new store.
REQ-025 Back-to-back: a request present in the IDLE cycle after an ack SHALL be accepted that cycle (no bubble beyond IDLE).

Reset
REQ-026 rst_i=1 at any clock edge, including mid-BUFFER with wb_valid_o high, SHALL force IDLE, clear latched registers, and all outputs 0 except idle_o=1, from the next cycle.
REQ-027 No acks SHALL be issued for a request interrupted by reset.

Verification (DATA_WIDTH=32, ADDR_WIDTH=32, INDEX_BITS=8)
REQ-028 Byte store hit, addr 0x0000_1236, data 0xAB -> cycle 2: cache_write_o=1, index 0x8D, byte_en 4'b0100, data 0x00AB_0000, st_ack_o=1.
REQ-029 Word store miss, addr 0x0000_2000, wb_ready_i low 3 cycles -> wb_valid_o high 4 cycles, payload stable, st_ack_o on the ready cycle.
REQ-030 Half store at addr 0x...01 or st_width_i=3 -> st_ack_o=1, st_err_o=1 in cycle 0, cache_read_o=0, wb_valid_o=0.
REQ-031 Simultaneous inv_req_i and st_req_i, invalidate hit -> invalidate acked cycle 2 with cache_en_o=4'b0010; store accepted cycle 3, acked cycle 5 on hit.
REQ-032 rst_i during BUFFER -> next cycle wb_valid_o=0, idle_o=1, no st_ack_o; a fresh store then completes normally.
REQ-033 DATA_WIDTH=64: double store at addr 0x...08 -> byte_en 8'hFF, data equals st_data_i, no error.
